// File: rtl/freelist_free_sequencer.sv
// Buffers up to two freed physical-register IDs per cycle from ROB commit and
// drains them one per cycle into the freelist. Optional counters: FREE_SEQ_STATS_EN.
module freelist_free_sequencer #(
  parameter int PD_W       = 7,
  parameter int BUF_DEPTH  = 4,
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        commit_valid,
  input  logic [2*PD_W-1:0] commit_pd,
  output logic              commit_ready,
  output logic              free_valid,
  output logic [PD_W-1:0]   free_pd,
  input  logic              fl_full,
  input  logic              flush_valid,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy
`ifdef FREE_SEQ_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_flush_drops
`endif
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH_HOLD} state_t;

  state_t            state_q, state_d;
  logic [PD_W-1:0]   fifo_q [BUF_DEPTH];
  logic [PD_W-1:0]   fifo_d [BUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              acc0, acc1, pop;
  logic [PTR_W-1:0]  wr1_ptr;

  always_comb begin
    commit_ready = (occ_q <= OCC_W'(BUF_DEPTH - 2)) && (state_q != S_FLUSH_HOLD) && !flush_valid;
    // ID 0 is the architectural x0 mapping and never returns to the freelist
    acc0 = commit_ready && commit_valid[0] && (commit_pd[0 +: PD_W] != '0);
    acc1 = commit_ready && commit_valid[1] && (commit_pd[PD_W +: PD_W] != '0);
    pop  = (occ_q != '0) && !fl_full && (state_q == S_DRAIN) && !flush_valid;

    free_valid = pop;
    free_pd    = pop ? fifo_q[head_q[AW-1:0]] : '0;
    wr1_ptr    = tail_q + PTR_W'(acc0);

    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    state_d = state_q;

    if (flush_valid) begin
      for (int i = 0; i < BUF_DEPTH; i++) fifo_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      state_d = S_FLUSH_HOLD;
    end else begin
      if (acc0) fifo_d[tail_q[AW-1:0]]  = commit_pd[0 +: PD_W];
      if (acc1) fifo_d[wr1_ptr[AW-1:0]] = commit_pd[PD_W +: PD_W];
      tail_d = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
      head_d = head_q + PTR_W'(pop);
      occ_d  = occ_q + OCC_W'(acc0) + OCC_W'(acc1) - OCC_W'(pop);
      unique case (state_q)
        S_IDLE:  if (acc0 || acc1) state_d = S_DRAIN;
        S_DRAIN: if (occ_d == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign occupancy = occ_q;
  assign busy      = (state_q != S_IDLE);

`ifdef FREE_SEQ_STATS_EN
  logic [31:0] stall_q, stall_d, drops_q, drops_d;
  logic [32:0] drops_sum;

  // Both counters saturate rather than wrap
  always_comb begin
    stall_d = stall_q;
    if ((|commit_valid) && !commit_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    drops_sum = {1'b0, drops_q} + 33'(occ_q);
    drops_d   = drops_q;
    if (flush_valid) drops_d = drops_sum[32] ? '1 : drops_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      stall_q <= stall_d;
      drops_q <= drops_d;
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_flush_drops  = drops_q;
`endif

endmodule

// File: tb/tb_freelist_free_sequencer.sv
// Directed, table-driven bench for freelist_free_sequencer plus hand-written
// wrap-around and mid-operation reset sequences.
module tb_freelist_free_sequencer;

  localparam int PD_W      = 7;
  localparam int BUF_DEPTH = 4;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        commit_valid;
  logic [PD_W-1:0]   pd0, pd1;
  logic              commit_ready;
  logic              free_valid;
  logic [PD_W-1:0]   free_pd;
  logic              fl_full;
  logic              flush_valid;
  logic [OCC_W-1:0]  occupancy;
  logic              busy;
`ifdef FREE_SEQ_STATS_EN
  logic [31:0]       stat_stall_cycles;
  logic [31:0]       stat_flush_drops;
`endif

  always #5 clk = ~clk;

  freelist_free_sequencer #(.PD_W(PD_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pd    ({pd1, pd0}),
    .commit_ready (commit_ready),
    .free_valid   (free_valid),
    .free_pd      (free_pd),
    .fl_full      (fl_full),
    .flush_valid  (flush_valid),
    .occupancy    (occupancy),
    .busy         (busy)
`ifdef FREE_SEQ_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_flush_drops  (stat_flush_drops)
`endif
  );

  typedef struct {
    logic [1:0]      cv;
    logic [PD_W-1:0] p0, p1;
    logic            fl, fls;
    logic            e_rdy, e_fv;
    logic [PD_W-1:0] e_pd;
    logic [OCC_W-1:0] e_occ;
    logic            e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] cv, input logic [6:0] p0, input logic [6:0] p1,
                     input logic fl, input logic fls, input logic rdy, input logic fv,
                     input logic [6:0] epd, input logic [2:0] occ, input logic bsy);
    vec_t v;
    v.cv = cv; v.p0 = p0; v.p1 = p1; v.fl = fl; v.fls = fls;
    v.e_rdy = rdy; v.e_fv = fv; v.e_pd = epd; v.e_occ = occ; v.e_busy = bsy;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    commit_valid = 2'b00; pd0 = '0; pd1 = '0; fl_full = 1'b0; flush_valid = 1'b0;
  endtask

  initial begin
    logic [PD_W-1:0] expq[$];
    int sent, got;

    rst = 1'b1;
    idle_inputs();

    //   cv     p0     p1     fl fls | rdy fv pd     occ busy
    // single free
    add(2'b01, 7'h25, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  1, 7'h25, 1, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    // ordering with x0 filter
    add(2'b11, 7'h20, 7'h21, 0, 0,   1,  0, 7'h00, 0, 0);
    add(2'b11, 7'h00, 7'h22, 0, 0,   1,  1, 7'h20, 2, 1);
    add(2'b11, 7'h23, 7'h24, 0, 0,   1,  1, 7'h21, 2, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   0,  1, 7'h22, 3, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  1, 7'h23, 2, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  1, 7'h24, 1, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    // back-pressure with freelist full
    add(2'b11, 7'h30, 7'h31, 1, 0,   1,  0, 7'h00, 0, 0);
    add(2'b11, 7'h32, 7'h33, 1, 0,   1,  0, 7'h00, 2, 1);
    add(2'b11, 7'h34, 7'h35, 1, 0,   0,  0, 7'h00, 4, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   0,  1, 7'h30, 4, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   0,  1, 7'h31, 3, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  1, 7'h32, 2, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  1, 7'h33, 1, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    // flush with occupancy 3 and same-cycle commits
    add(2'b11, 7'h40, 7'h41, 1, 0,   1,  0, 7'h00, 0, 0);
    add(2'b01, 7'h42, 7'h00, 1, 0,   1,  0, 7'h00, 2, 1);
    add(2'b11, 7'h43, 7'h44, 1, 1,   0,  0, 7'h00, 3, 1);
    add(2'b11, 7'h45, 7'h46, 0, 0,   0,  0, 7'h00, 0, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    // flush while draining suppresses the pop
    add(2'b01, 7'h50, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    add(2'b00, 7'h00, 7'h00, 0, 1,   0,  0, 7'h00, 1, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   0,  0, 7'h00, 0, 1);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    // pair of x0 IDs leaves the block idle
    add(2'b11, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);
    add(2'b00, 7'h00, 7'h00, 0, 0,   1,  0, 7'h00, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      commit_valid = tbl[i].cv; pd0 = tbl[i].p0; pd1 = tbl[i].p1;
      fl_full = tbl[i].fl; flush_valid = tbl[i].fls;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(commit_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_fvalid", i), 32'(free_valid), 32'(tbl[i].e_fv));
      chk($sformatf("row%0d_fpd", i), 32'(free_pd), 32'(tbl[i].e_pd));
      chk($sformatf("row%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end

    // wrap-around: 10 pairs with continuous draining
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (sent < 10) begin
        commit_valid = 2'b11;
        pd0 = 7'(8'h60 + 2 * sent);
        pd1 = 7'(8'h61 + 2 * sent);
      end
      #1;
      if (free_valid) begin
        if (expq.size() == 0) chk("wrap_spurious", 32'(free_valid), 32'd0);
        else begin
          chk($sformatf("wrap_order%0d", got), 32'(free_pd), 32'(expq.pop_front()));
          got++;
        end
      end
      if (commit_ready && sent < 10) begin
        expq.push_back(pd0);
        expq.push_back(pd1);
        sent++;
      end
    end
    chk("wrap_sent", 32'(sent), 32'd10);
    chk("wrap_count", 32'(got), 32'd20);

    // reset with two entries buffered
    @(negedge clk);
    idle_inputs(); commit_valid = 2'b11; pd0 = 7'h70; pd1 = 7'h71; fl_full = 1'b1;
    @(negedge clk);
    idle_inputs(); fl_full = 1'b1;
    #1;
    chk("rstmid_pre_occ", 32'(occupancy), 32'd2);
    @(negedge clk);
    rst = 1'b1; commit_valid = 2'b11; pd0 = 7'h72; pd1 = 7'h73; fl_full = 1'b1;
    @(negedge clk);
    rst = 1'b0; idle_inputs();
    #1;
    chk("rstmid_fvalid", 32'(free_valid), 32'd0);
    chk("rstmid_fpd", 32'(free_pd), 32'd0);
    chk("rstmid_occ", 32'(occupancy), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(commit_ready), 32'd1);
`ifdef FREE_SEQ_STATS_EN
    chk("rstmid_stall", stat_stall_cycles, 32'd0);
    chk("rstmid_drops", stat_flush_drops, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstmid_quiet%0d", k), 32'(free_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
